// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones, clear has priority over inc.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory freeze, branch
// squash and load-use bubbles, with saturating event statistics.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 dmem_ready,
  output logic                 pc_we,
  output logic                 if_id_we,
  output logic                 id_ex_we,
  output logic                 ex_mem_we,
  output logic                 mem_wb_we,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 pc_sel_target,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  // Remaining-bubble count after the first load-use cycle (at most 2).
  localparam logic [1:0] LUS_M1 = 2'(LOAD_USE_STALL - 1);
  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;

  state_e          state_reg, state_next;
  logic [1:0]      rem_reg, rem_next;
  logic            freeze, hazard;
  logic            stall_inc, flush_inc;
  logic [TO_W-1:0] wait_cnt;

  assign freeze = mem_req && !dmem_ready;
  assign hazard = ex_mem_read && (ex_rd != REG_ZERO) &&
                  ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  // Prioritised decision: reset > memory freeze > branch > load-use > normal.
  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    mem_wb_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    pc_sel_target = 1'b0;
    flush_inc     = 1'b0;
    state_next    = RUN;
    rem_next      = 2'd0;
    if (areset) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_we    = 1'b0;
      ex_mem_we   = 1'b0;
      mem_wb_we   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze) begin
      // Whole pipeline holds; hazard inputs are re-presented once ready.
      pc_we      = 1'b0;
      if_id_we   = 1'b0;
      id_ex_we   = 1'b0;
      ex_mem_we  = 1'b0;
      mem_wb_we  = 1'b0;
      state_next = MEM_WAIT;
    end else if (ex_branch_taken) begin
      // Squash the two wrong-path slots; any pending bubbles are dropped.
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      pc_sel_target = 1'b1;
      flush_inc     = 1'b1;
    end else if ((state_reg == LU_STALL) || hazard) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
      if (state_reg == LU_STALL) begin
        if (rem_reg > 2'd1) begin
          state_next = LU_STALL;
          rem_next   = rem_reg - 2'd1;
        end
      end else if (LOAD_USE_STALL > 1) begin
        state_next = LU_STALL;
        rem_next   = LUS_M1;
      end
    end
  end

  assign stall_inc = !pc_we && !areset;

  // State and remaining-bubble registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_reg <= RUN;
      rem_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
    end
  end

  // Sticky timeout flag: set on the freeze cycle that completes the budget.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mem_err <= 1'b0;
    end else if ((MEM_TIMEOUT > 0) && freeze && (wait_cnt == TO_LAST)) begin
      mem_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .areset(areset), .clr(1'b0), .inc(stall_inc), .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .areset(areset), .clr(1'b0), .inc(flush_inc), .count(flush_cnt)
  );

  sat_counter #(.W(TO_W)) u_wait_cnt (
    .clk(clk), .areset(areset), .clr(!freeze),
    .inc(freeze && (MEM_TIMEOUT > 0)), .count(wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations share one stimulus
// stream and are compared every cycle against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       areset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, dmem_ready;

  logic a_pc_we, a_if_id_we, a_id_ex_we, a_ex_mem_we, a_mem_wb_we;
  logic a_if_id_flush, a_id_ex_flush, a_pc_sel_target, a_mem_err;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we, b_mem_wb_we;
  logic b_if_id_flush, b_id_ex_flush, b_pc_sel_target, b_mem_err;
  logic [3:0] b_stall_cnt, b_flush_cnt;

  pipeline_hazard_ctrl #(.LOAD_USE_STALL(1), .MEM_TIMEOUT(8), .CNT_W(32)) dut_a (
    .clk(clk), .areset(areset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .pc_we(a_pc_we), .if_id_we(a_if_id_we),
    .id_ex_we(a_id_ex_we), .ex_mem_we(a_ex_mem_we), .mem_wb_we(a_mem_wb_we),
    .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
    .pc_sel_target(a_pc_sel_target), .mem_err(a_mem_err),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipeline_hazard_ctrl #(.LOAD_USE_STALL(3), .MEM_TIMEOUT(0), .CNT_W(4)) dut_b (
    .clk(clk), .areset(areset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .pc_we(b_pc_we), .if_id_we(b_if_id_we),
    .id_ex_we(b_id_ex_we), .ex_mem_we(b_ex_mem_we), .mem_wb_we(b_mem_wb_we),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .pc_sel_target(b_pc_sel_target), .mem_err(b_mem_err),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  // Control vector order: pc, if_id, id_ex, ex_mem, mem_wb we; if_id, id_ex flush; pc_sel.
  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {a_pc_we, a_if_id_we, a_id_ex_we, a_ex_mem_we, a_mem_wb_we,
                  a_if_id_flush, a_id_ex_flush, a_pc_sel_target};
  assign ctl_b = {b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we, b_mem_wb_we,
                  b_if_id_flush, b_id_ex_flush, b_pc_sel_target};

  // Reference model: per configuration, bubbles still owed, counters, timeout.
  int     lus [2] = '{1, 3};
  int     tmo [2] = '{8, 0};
  longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};
  int     bub [2];
  int     wrun[2];
  longint scnt[2], fcnt[2];
  bit     merr[2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic bit hazard_now();
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  endfunction

  function automatic logic [7:0] exp_ctl(int k);
    if (areset)                    return 8'b00000110;
    if (mem_req && !dmem_ready)    return 8'b00000000;
    if (ex_branch_taken)           return 8'b11111111;
    if (bub[k] > 0 || hazard_now()) return 8'b00111010;
    return 8'b11111000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      bub[k] = 0; wrun[k] = 0; scnt[k] = 0; fcnt[k] = 0; merr[k] = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      if (areset) begin
        bub[k] = 0; wrun[k] = 0; scnt[k] = 0; fcnt[k] = 0; merr[k] = 0;
      end else if (mem_req && !dmem_ready) begin
        if (scnt[k] < cmax[k]) scnt[k]++;
        wrun[k]++;
        if (tmo[k] != 0 && wrun[k] >= tmo[k]) merr[k] = 1;
        bub[k] = 0;
      end else begin
        wrun[k] = 0;
        if (ex_branch_taken) begin
          if (fcnt[k] < cmax[k]) fcnt[k]++;
          bub[k] = 0;
        end else if (bub[k] > 0) begin
          if (scnt[k] < cmax[k]) scnt[k]++;
          bub[k]--;
        end else if (hazard_now()) begin
          if (scnt[k] < cmax[k]) scnt[k]++;
          bub[k] = lus[k] - 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input string what);
    chk({what, " a.ctl"},   {56'd0, ctl_a},       {56'd0, exp_ctl(0)});
    chk({what, " a.err"},   {63'd0, a_mem_err},   {63'd0, merr[0]});
    chk({what, " a.stall"}, {32'd0, a_stall_cnt}, scnt[0]);
    chk({what, " a.flush"}, {32'd0, a_flush_cnt}, fcnt[0]);
    chk({what, " b.ctl"},   {56'd0, ctl_b},       {56'd0, exp_ctl(1)});
    chk({what, " b.err"},   {63'd0, b_mem_err},   {63'd0, merr[1]});
    chk({what, " b.stall"}, {60'd0, b_stall_cnt}, scnt[1]);
    chk({what, " b.flush"}, {60'd0, b_flush_cnt}, fcnt[1]);
    $display("cyc %0d %s rst=%0b ld=%0b rd=%0d rs=%0d/%0b rt=%0d/%0b br=%0b mq=%0b rdy=%0b | a=%b s%0d f%0d e%0b | b=%b s%0d f%0d",
             cyc, what, areset, ex_mem_read, ex_rd, id_rs, id_uses_rs, id_rt, id_uses_rt,
             ex_branch_taken, mem_req, dmem_ready, ctl_a, a_stall_cnt, a_flush_cnt,
             a_mem_err, ctl_b, b_stall_cnt, b_flush_cnt);
  endtask

  // Apply inputs, check settled outputs, then clock both DUTs and the model.
  task automatic step(input string what, input logic ld, input logic [4:0] rd,
                      input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                      input logic urt, input logic br, input logic mq, input logic rdy);
    ex_mem_read = ld; ex_rd = rd; id_rs = rs; id_uses_rs = urs;
    id_rt = rt; id_uses_rt = urt; ex_branch_taken = br; mem_req = mq; dmem_ready = rdy;
    #2;
    check_all(what);
    @(posedge clk);
    model_clock();
    cyc++;
    #1;
  endtask

  task automatic idle(input string what);
    step(what, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
  endtask

  initial begin
    areset = 1'b1;
    ex_mem_read = 0; ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_branch_taken = 0; mem_req = 0; dmem_ready = 1;
    model_reset();
    @(posedge clk); #1;
    idle("reset");
    idle("reset");
    areset = 1'b0;
    idle("run");

    // Load-use on rs: a stalls 1 cycle, b stalls 3 cycles.
    step("lu_rs", 1, 5'd5, 5'd5, 1, 5'd2, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) idle("after_lu");
    // Load-use on rt, and the unused-source case.
    step("lu_rt", 1, 5'd7, 5'd1, 1, 5'd7, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) idle("after_lu");
    step("lu_unused", 1, 5'd7, 5'd7, 0, 5'd7, 0, 0, 0, 1);
    // Register $0 never stalls.
    step("lu_r0", 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 1);
    idle("after_r0");

    // Branch during the second LU_STALL cycle of b aborts its bubbles.
    step("lu_br", 1, 5'd9, 5'd9, 1, 5'd0, 0, 0, 0, 1);
    idle("lu_br_s1");
    step("lu_br_take", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 1);
    idle("lu_br_after");
    idle("lu_br_after");

    // Memory freeze with a pending branch: frozen 4 cycles, flush on ready.
    for (int i = 0; i < 4; i++) step("freeze_br", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0);
    step("freeze_br_rdy", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1);
    idle("freeze_after");

    // Freeze with a pending load-use: hazard evaluated on the ready cycle.
    for (int i = 0; i < 2; i++) step("freeze_lu", 1, 5'd4, 5'd4, 1, 5'd0, 0, 0, 1, 0);
    step("freeze_lu_rdy", 1, 5'd4, 5'd4, 1, 5'd0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) idle("freeze_lu_after");

    // Timeout: 10 not-ready cycles; a sets mem_err after the 8th and keeps it.
    for (int i = 0; i < 10; i++) step("timeout", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) idle("timeout_after");

    // Asynchronous reset mid-wait.
    for (int i = 0; i < 3; i++) step("wait", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
    mem_req = 1; dmem_ready = 0;
    #2;
    areset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk); model_clock(); cyc++; #1;
    areset = 1'b0;
    idle("post_rst");

    // Reset mid LU_STALL of b.
    step("lu_rst", 1, 5'd3, 5'd3, 1, 5'd0, 0, 0, 0, 1);
    areset = 1'b1;
    model_reset();
    #1;
    check_all("lu_rst_async");
    @(posedge clk); model_clock(); cyc++; #1;
    areset = 1'b0;
    idle("lu_rst_post");

    // Drive b's 4-bit stall counter into saturation.
    for (int i = 0; i < 7; i++) begin
      step("sat_lu", 1, 5'd6, 5'd0, 0, 5'd6, 1, 0, 0, 1);
      idle("sat_gap");
      idle("sat_gap");
    end
    idle("sat_hold");

    // Randomised traffic with a narrow register range so hazards are common.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline; produces the `write_enable` and `aload` (synchronous-style squash via async-load-to-zero) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It detects load-use hazards, squashes wrong-path instructions on taken branches resolved in EX, and freezes the machine while data memory is not ready. A small FSM sequences multi-cycle stalls; saturating counters expose stall/flush statistics.

## Interface
Parameters:
- `LOAD_USE_STALL`, 1, bubbles inserted per load-use hazard (1 with MEM→EX forwarding, 2 without); legal 1..3
- `MEM_TIMEOUT`, 255, consecutive not-ready cycles before `mem_err` sets; 0 disables
- `CNT_W`, 32, width of statistics counters

Ports:
- `clk` in 1: rising-edge clock
- `areset` in 1: asynchronous, active-high reset
- `id_rs`, `id_rt` in 5 each: source registers of instruction in ID
- `id_uses_rs`, `id_uses_rt` in 1 each: ID instruction reads that source
- `ex_mem_read` in 1: instruction in EX is a load
- `ex_rd` in 5: destination of instruction in EX
- `ex_branch_taken` in 1: branch in EX resolved taken this cycle
- `mem_req` in 1: instruction in MEM accesses data memory
- `dmem_ready` in 1: data memory completes access this cycle
- `pc_we`, `if_id_we`, `id_ex_we`, `ex_mem_we`, `mem_wb_we` out 1 each: register write enables
- `if_id_flush`, `id_ex_flush` out 1 each: drive `aload` of IF/ID, ID/EX (clears to NOP)
- `pc_sel_target` out 1: PC loads branch target
- `mem_err` out 1: sticky memory-timeout flag
- `stall_cnt`, `flush_cnt` out `CNT_W` each: saturating event counters

## Operation
- States: RUN, LU_STALL, MEM_WAIT. Control outputs are combinational from state + inputs; state/counters registered.
- Priority each cycle: MEM freeze > branch flush > load-use > normal.
- MEM freeze: `mem_req && !dmem_ready` → all `*_we`=0, `pc_we`=0, no flush, `pc_sel_target`=0; go/stay MEM_WAIT. Branch/load-use evaluation suppressed (pipeline frozen, inputs re-presented next cycle). Leave MEM_WAIT on first cycle `dmem_ready`=1; that cycle is evaluated as RUN.
- Branch flush: `ex_branch_taken` → `pc_we`=1, `pc_sel_target`=1, `if_id_flush`=`id_ex_flush`=1, other enables 1; aborts any LU_STALL (return RUN, remaining bubbles dropped); `flush_cnt`+1.
- Load-use hazard: `ex_mem_read && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd))` → `pc_we`=`if_id_we`=0, `id_ex_flush`=1, EX/MEM, MEM/WB enabled; if `LOAD_USE_STALL`>1 enter LU_STALL with remaining=`LOAD_USE_STALL`-1.
- LU_STALL: same outputs as load-use cycle (hazard inputs ignored, load has left EX); decrement remaining; at 0 → RUN.
- `stall_cnt`+1 on every cycle with `pc_we`=0 (freeze or bubble). Both counters saturate at all-ones.
- `mem_err`: internal wait counter increments each MEM_WAIT cycle, clears on exit; reaching `MEM_TIMEOUT` sets `mem_err` (sticky until reset). Freeze continues.
- Register $0 never creates a hazard.

## Timing
- Reset (async, immediate): state RUN, counters 0, `mem_err`=0; while `areset`=1 all `*_we`=0, `pc_we`=0, `pc_sel_target`=0, `if_id_flush`=`id_ex_flush`=1.
- Zero-cycle decision latency: hazard seen in cycle N gates the cycle-N clock edge.
- Load-use costs exactly `LOAD_USE_STALL` cycles; branch costs 2 squashed slots (IF/ID, ID/EX), 1 cycle of flush assertion.
- Reset mid-stall or mid-wait: returns to RUN, no residual bubbles.
- `areset` deassertion: first post-reset cycle is normal RUN evaluation.

## Structure
- Package `pipe_ctrl_pkg`: state enum (RUN, LU_STALL, MEM_WAIT), `REG_IDX_W`=5, `REG_ZERO`=5'd0.
- Sub-module `sat_counter` (width param, inc, async reset) instantiated for `stall_cnt`, `flush_cnt`, and the timeout counter.

## Test plan
- Load `lw $5` in EX, ID reads rs=$5, `LOAD_USE_STALL`=1 → one cycle `pc_we`=0, `if_id_we`=0, `id_ex_flush`=1; next cycle all enables 1; `stall_cnt`=1.
- Same with `LOAD_USE_STALL`=3 and `ex_rd`=0 case → 3 bubble cycles, `stall_cnt`=3; `ex_rd`=0 → no stall.
- `ex_branch_taken` during cycle 2 of LU_STALL → flush asserted, `pc_sel_target`=1, state RUN next cycle, `flush_cnt`=1.
- `mem_req`=1, `dmem_ready`=0 for 4 cycles with concurrent `ex_branch_taken`=1 → all enables 0 for 4 cycles, branch flush fires on 5th (ready) cycle.
- `MEM_TIMEOUT`=8, ready held low 10 cycles → `mem_err` rises after 8th wait cycle, stays 1 after ready returns until `areset`.
- Assert `areset` mid-MEM_WAIT → outputs immediately at reset values, counters 0, RUN after release; force `stall_cnt` near saturation (`CNT_W`=4) → holds at 15.
